// File: rtl/display_capture.sv
// Sample-and-hold stage for the 7-segment hex driver. It captures a CPU value, rate-limits
// updates to refresh ticks, and pages the word onto six digits under a debounced button.
module display_capture #(
  parameter int REFRESH_CYCLES  = 2_500_000,  // >= 2
  parameter int DEBOUNCE_CYCLES = 500_000     // >= 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_data_valid,
  input  logic [31:0] i_data,
  input  logic        i_freeze,
  input  logic        i_btn_page,
  output logic [31:0] o_data,
  output logic        o_page,
  output logic        o_update
);

  localparam int REF_W = $clog2(REFRESH_CYCLES);
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
  // Accept on the edge where the mismatch count would reach DEBOUNCE_CYCLES-1.
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 2);

  logic [REF_W-1:0] r_ref_cnt;
  logic [31:0]      r_pending;
  logic             r_pending_flag;
  logic [31:0]      r_shown;
  logic             r_xfer_d;
  logic [1:0]       r_sync;
  logic             r_btn_db;
  logic             r_btn_db_d;
  logic [DEB_W-1:0] r_db_cnt;
  logic             r_page;
  logic [31:0]      r_data;
  logic             r_update;

  logic             w_tick;
  logic             w_capture;
  logic             w_transfer;
  logic             w_btn_s;
  logic             w_btn_mismatch;
  logic             w_db_accept;
  logic             w_db_rise;
  logic [31:0]      w_page_data;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    w_tick         = 1'b0;
    w_capture      = 1'b0;
    w_transfer     = 1'b0;
    w_btn_s        = 1'b0;
    w_btn_mismatch = 1'b0;
    w_db_accept    = 1'b0;
    w_db_rise      = 1'b0;
    w_page_data    = {8'h00, r_shown[23:0]};

    w_tick         = (r_ref_cnt == REF_LAST);
    w_capture      = i_data_valid & ~i_freeze;
    w_transfer     = w_tick & r_pending_flag & ~i_freeze;
    w_btn_s        = r_sync[1];
    w_btn_mismatch = w_btn_s ^ r_btn_db;
    w_db_accept    = w_btn_mismatch & (r_db_cnt == DEB_LAST);
    w_db_rise      = r_btn_db & ~r_btn_db_d;
    if (r_page) begin
      w_page_data = {24'h000000, r_shown[31:24]};
    end
  end

  // The refresh counter runs free and ignores freeze.
  // NOTE: sequential state is always written with non-blocking assignments.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ref_cnt <= '0;
    end else if (w_tick) begin
      r_ref_cnt <= '0;
    end else begin
      r_ref_cnt <= r_ref_cnt + REF_W'(1);
    end
  end

  // A new capture wins over the clear caused by a simultaneous transfer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending      <= '0;
      r_pending_flag <= 1'b0;
      r_shown        <= '0;
      r_xfer_d       <= 1'b0;
    end else begin
      r_xfer_d <= w_transfer;
      if (w_transfer) begin
        r_shown <= r_pending;
      end
      if (w_capture) begin
        r_pending      <= i_data;
        r_pending_flag <= 1'b1;
      end else if (w_transfer) begin
        r_pending_flag <= 1'b0;
      end
    end
  end

  // The button is asynchronous: two flops tame metastability before the debounce counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync     <= 2'b00;
      r_btn_db   <= 1'b0;
      r_btn_db_d <= 1'b0;
      r_db_cnt   <= '0;
      r_page     <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], i_btn_page};
      r_btn_db_d <= r_btn_db;
      if (!w_btn_mismatch) begin
        r_db_cnt <= '0;
      end else if (w_db_accept) begin
        r_btn_db <= w_btn_s;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DEB_W'(1);
      end
      if (w_db_rise) begin
        r_page <= ~r_page;
      end
    end
  end

  // The output register follows the shown value every cycle, so a page flip appears without o_update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data   <= '0;
      r_update <= 1'b0;
    end else begin
      r_data   <= w_page_data;
      r_update <= r_xfer_d;
    end
  end

  assign o_data   = r_data;
  assign o_page   = r_page;
  assign o_update = r_update;

endmodule

// File: tb/tb_display_capture.sv
// Directed and randomized bench for display_capture. A cycle-level reference model tracks ticks by
// edge count, keeps the button history in queues, and compares o_data/o_page/o_update every cycle.
module tb_display_capture;
  localparam int R = 8;
  localparam int D = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] data  = '0;
  logic        freeze = 1'b0;
  logic        btn   = 1'b0;
  logic [31:0] o_data;
  logic        o_page;
  logic        o_update;

  int errors = 0;
  int checks = 0;
  int upd_count = 0;

  // Reference model state
  int unsigned m_edges;
  logic [31:0] m_pending, m_shown, m_data;
  bit          m_flag, m_page, m_update, m_xfer_prev, m_rise_pending, m_db;
  bit          m_raw_q[$];
  bit          m_mis_q[$];

  always #5 clk = ~clk;

  display_capture #(.REFRESH_CYCLES(R), .DEBOUNCE_CYCLES(D)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_data_valid(valid),
    .i_data      (data),
    .i_freeze    (freeze),
    .i_btn_page  (btn),
    .o_data      (o_data),
    .o_page      (o_page),
    .o_update    (o_update)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_edges = 0;
    m_pending = '0; m_shown = '0; m_data = '0;
    m_flag = 0; m_page = 0; m_update = 0; m_xfer_prev = 0; m_rise_pending = 0; m_db = 0;
    m_raw_q.delete(); m_raw_q.push_back(1'b0); m_raw_q.push_back(1'b0);
    m_mis_q.delete();
  endtask

  // One rising edge of the model, computed from the pre-edge state and the current inputs.
  task automatic model_edge();
    bit tick, xfer, s, db_rise;
    logic [31:0] nd;
    m_edges++;
    tick = ((m_edges % R) == 0);
    xfer = tick && m_flag && !freeze;
    nd = m_page ? {24'h0, m_shown[31:24]} : {8'h0, m_shown[23:0]};
    m_update = m_xfer_prev;
    m_xfer_prev = xfer;
    m_data = nd;
    if (xfer) m_shown = m_pending;
    if (valid && !freeze) begin
      m_pending = data;
      m_flag = 1;
    end else if (xfer) begin
      m_flag = 0;
    end
    if (m_rise_pending) m_page = !m_page;
    s = m_raw_q[0];
    m_raw_q.push_back(btn);
    void'(m_raw_q.pop_front());
    db_rise = 0;
    if (s != m_db) begin
      m_mis_q.push_back(s);
      if (m_mis_q.size() == D - 1) begin
        db_rise = s;
        m_db = s;
        m_mis_q.delete();
      end
    end else begin
      m_mis_q.delete();
    end
    m_rise_pending = db_rise;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    if (o_update === 1'b1) upd_count++;
    check("o_data", o_data, m_data);
    check("o_page", {31'b0, o_page}, {31'b0, m_page});
    check("o_update", {31'b0, o_update}, {31'b0, m_update});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Leaves the bench so that the next edge is a refresh tick.
  task automatic wait_tick();
    for (int i = 0; i < R && (m_edges % R) != R - 1; i++) step();
  endtask

  task automatic do_reset(input int cycles);
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    check("rst_data", o_data, 32'h0);
    check("rst_page", {31'b0, o_page}, 32'h0);
    check("rst_update", {31'b0, o_update}, 32'h0);
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int btn_hold;

  initial begin
    m_reset();
    do_reset(3);
    run(2);

    // Reset and basic capture
    upd_count = 0;
    valid = 1; data = 32'h12345678; step(); valid = 0;
    run(R + 2);
    check("basic_data", o_data, 32'h00345678);
    check("basic_one_update", upd_count, 32'd1);

    // Last value wins
    wait_tick(); step();
    valid = 1; data = 32'hAAAAAAAA; step();
    data = 32'h0BBBBBBB; step(); valid = 0;
    run(R + 2);
    check("last_wins", o_data, 32'h00BBBBBB);

    // Capture on the tick cycle: the old pending value is shown first
    wait_tick(); step();
    valid = 1; data = 32'h00ABCDEF; step(); valid = 0;
    wait_tick();
    valid = 1; data = 32'h00CCCCCC; step(); valid = 0;
    run(2);
    check("simul_prev", o_data, 32'h00ABCDEF);
    run(R);
    check("simul_next", o_data, 32'h00CCCCCC);

    // Paging
    wait_tick(); step();
    valid = 1; data = 32'hDEADBEEF; step(); valid = 0;
    run(R + 2);
    check("page0_data", o_data, 32'h00ADBEEF);
    upd_count = 0;
    btn = 1; run(10);
    check("page1_page", {31'b0, o_page}, 32'h1);
    check("page1_data", o_data, 32'h000000DE);
    btn = 0; run(10);
    btn = 1; run(10);
    check("page_back_page", {31'b0, o_page}, 32'h0);
    check("page_back_data", o_data, 32'h00ADBEEF);
    btn = 0; run(10);
    check("page_no_update", upd_count, 32'd0);

    // Debounce: short glitches are rejected, a steady press toggles once
    for (int k = 0; k < 10; k++) begin
      btn = 1; run(2);
      btn = 0; run(2);
    end
    check("glitch_page", {31'b0, o_page}, 32'h0);
    btn = 1; run(6);
    btn = 0; run(10);
    check("steady_press_page", {31'b0, o_page}, 32'h1);
    btn = 1; run(10);
    btn = 0; run(10);
    check("page_restore", {31'b0, o_page}, 32'h0);

    // Freeze blocks capture
    freeze = 1; valid = 1; data = 32'h11111111;
    run(3 * R);
    valid = 0;
    check("freeze_ignore", o_data, 32'h00ADBEEF);
    freeze = 0; run(R + 2);
    check("freeze_no_pending", o_data, 32'h00ADBEEF);

    // Freeze holds a pending value until released
    wait_tick(); step();
    valid = 1; data = 32'h22222222; step(); valid = 0;
    freeze = 1; run(2 * R);
    check("freeze_hold", o_data, 32'h00ADBEEF);
    freeze = 0; run(R + 1);
    check("freeze_release", o_data, 32'h00222222);

    // Reset mid-operation with a pending value and page 1
    btn = 1; run(10);
    btn = 0; run(10);
    check("pre_reset_page", {31'b0, o_page}, 32'h1);
    wait_tick(); step();
    valid = 1; data = 32'h33333333; step(); valid = 0;
    do_reset(1);
    upd_count = 0;
    run(3 * R);
    check("post_reset_data", o_data, 32'h0);
    check("post_reset_page", {31'b0, o_page}, 32'h0);
    check("post_reset_no_update", upd_count, 32'd0);

    // Randomized traffic against the model
    btn_hold = 0;
    for (int i = 0; i < 1500; i++) begin
      valid = ($urandom_range(3) == 0);
      data  = $urandom;
      if ($urandom_range(19) == 0) freeze = ~freeze;
      if (btn_hold == 0) begin
        btn = 1'($urandom_range(1));
        btn_hold = $urandom_range(12, 1);
      end
      btn_hold--;
      if (i == 700) do_reset(2);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
